reg_file_micro: RTL

Register file between the MicroBlaze GPIO port and the DSP datapath on the `clockdsp` domain. It decodes 32-bit command words written by firmware on GPO and drives static control outputs into the datapath. It also captures a burst of datapath samples into an internal log memory and returns read data and status on GPI. It connects directly to GPO (`in_micro_to_rf_data`) and GPI (`out_rf_to_micro_data`) of the processor subsystem.

---
 rtl/reg_file_pkg.sv | 31 +++
 rtl/reg_file_micro_if.sv | 20 ++
 rtl/rf_log_ram.sv | 31 +++
 rtl/reg_file_micro.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants for reg_file_micro.
// Contents: command-word field positions, opcode values, the log FSM state encoding and
// the bit position of the count field in the status word.
package reg_file_pkg;

    // Command word layout: [31:24] opcode, [23] strobe, [22:0] payload
    localparam int unsigned OPC_MSB     = 31;
    localparam int unsigned OPC_LSB     = 24;
    localparam int unsigned STROBE_BIT  = 23;
    localparam int unsigned PAYLOAD_MSB = 22;
    localparam int unsigned NB_OPC      = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned NB_PAYLOAD  = PAYLOAD_MSB + 1;

    // Status word: count starts at this bit, state sits in [1:0]
    localparam int unsigned STATUS_CNT_LSB = 16;

    localparam logic [NB_OPC-1:0] OP_SOFT_RST   = 8'h01;
    localparam logic [NB_OPC-1:0] OP_ENABLE     = 8'h02;
    localparam logic [NB_OPC-1:0] OP_PHASE      = 8'h03;
    localparam logic [NB_OPC-1:0] OP_LOG_START  = 8'h04;
    localparam logic [NB_OPC-1:0] OP_LOG_READ   = 8'h05;
    localparam logic [NB_OPC-1:0] OP_LOG_STATUS = 8'h06;
    localparam logic [NB_OPC-1:0] OP_ECHO       = 8'h07;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFull    = 2'd2
    } log_state_e;

endpackage

// File: rtl/reg_file_micro_if.sv
// GPIO bus between the MicroBlaze subsystem and reg_file_micro.
//   in_micro_to_rf_data  : command word driven by firmware on GPO
//   out_rf_to_micro_data : response word returned on GPI
// master = processor side, slave = register file side.
interface reg_file_micro_if #(
    parameter int unsigned NB_GPIOS = 32
);
    logic [NB_GPIOS-1:0] in_micro_to_rf_data;
    logic [NB_GPIOS-1:0] out_rf_to_micro_data;

    modport master (
        output in_micro_to_rf_data,
        input  out_rf_to_micro_data
    );

    modport slave (
        input  in_micro_to_rf_data,
        output out_rf_to_micro_data
    );
endinterface

// File: rtl/rf_log_ram.sv
// Simple dual-port log memory: one write port, one registered read port.
//   clk_i   : clock
//   we_i    : write enable, waddr_i / wdata_i : write address / data
//   re_i    : read enable, raddr_i : read address
//   rdata_o : read data, valid the clock after re_i
// Read-first: a read of the address being written returns the old word.
// No reset so the array maps onto block RAM.
module rf_log_ram #(
    parameter int unsigned NB_LOG    = 16,
    parameter int unsigned LOG_DEPTH = 1024,
    parameter int unsigned NB_ADDR   = $clog2(LOG_DEPTH)
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [NB_ADDR-1:0] waddr_i,
    input  logic [NB_LOG-1:0]  wdata_i,
    input  logic               re_i,
    input  logic [NB_ADDR-1:0] raddr_i,
    output logic [NB_LOG-1:0]  rdata_o
);
    logic [NB_LOG-1:0] mem_q [LOG_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end
endmodule

// File: rtl/reg_file_micro.sv
// Register file between MicroBlaze GPIO and the DSP datapath (clockdsp domain).
// Ports:
//   clock, in_reset           : clock, asynchronous active-high reset
//   gpio (slave)              : GPO command word in, GPI response word out
//   in_log_data, in_log_valid : datapath sample stream to capture
//   out_soft_reset            : datapath soft reset level
//   out_tx_enable/out_rx_enable, out_phase_sel : static datapath controls
// A command executes on a rising edge of the strobe bit. The command is registered at
// the edge-detect clock, executed one clock later (controls, FSM, RAM read issued) and
// the response register loads one clock after that.
module reg_file_micro
    import reg_file_pkg::*;
#(
    parameter int unsigned NB_GPIOS  = 32,
    parameter int unsigned NB_LOG    = 16,
    parameter int unsigned LOG_DEPTH = 1024
) (
    input  logic              clock,
    input  logic              in_reset,
    reg_file_micro_if.slave   gpio,
    input  logic [NB_LOG-1:0] in_log_data,
    input  logic              in_log_valid,
    output logic              out_soft_reset,
    output logic              out_tx_enable,
    output logic              out_rx_enable,
    output logic [1:0]        out_phase_sel
);
    localparam int unsigned NB_ADDR = $clog2(LOG_DEPTH);
    localparam int unsigned NB_CNT  = NB_ADDR + 1;
    // Count field is clipped if it would run past the top of the response word
    localparam int unsigned NB_CNT_FIELD =
        (NB_CNT < NB_GPIOS - STATUS_CNT_LSB) ? NB_CNT : NB_GPIOS - STATUS_CNT_LSB;
    localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(LOG_DEPTH - 1);

    // ---------------- command capture ----------------
    logic                  strobe_q;
    logic                  strobe_rise;
    logic                  exec_q;
    logic [NB_OPC-1:0]     op_q;
    logic [NB_PAYLOAD-1:0] payload_q;

    assign strobe_rise = gpio.in_micro_to_rf_data[STROBE_BIT] & ~strobe_q;

    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            strobe_q  <= 1'b0;
            exec_q    <= 1'b0;
            op_q      <= '0;
            payload_q <= '0;
        end else begin
            strobe_q <= gpio.in_micro_to_rf_data[STROBE_BIT];
            exec_q   <= strobe_rise;
            if (strobe_rise) begin
                op_q      <= gpio.in_micro_to_rf_data[OPC_MSB:OPC_LSB];
                payload_q <= gpio.in_micro_to_rf_data[PAYLOAD_MSB:0];
            end
        end
    end

    logic start_cmd;
    assign start_cmd = exec_q && (op_q == OP_LOG_START);

    // ---------------- static controls ----------------
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            out_soft_reset <= 1'b0;
            out_tx_enable  <= 1'b0;
            out_rx_enable  <= 1'b0;
            out_phase_sel  <= 2'b00;
        end else if (exec_q) begin
            case (op_q)
                OP_SOFT_RST: out_soft_reset <= payload_q[0];
                OP_ENABLE: begin
                    out_tx_enable <= payload_q[0];
                    out_rx_enable <= payload_q[1];
                end
                OP_PHASE:    out_phase_sel <= payload_q[1:0];
                default: ;
            endcase
        end
    end

    // ---------------- log FSM ----------------
    log_state_e         state_q, state_d;
    logic [NB_CNT-1:0]  count_q, count_d;
    logic               log_we;
    logic [NB_ADDR-1:0] log_waddr;

    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (start_cmd) begin
            // Restart from any state; a sample arriving this cycle is dropped
            state_d = StCapture;
            count_d = '0;
        end else begin
            unique case (state_q)
                StCapture: begin
                    if (in_log_valid) begin
                        count_d = count_q + 1'b1;
                        if (count_q == LAST_IDX) begin
                            state_d = StFull;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        log_we    = (state_q == StCapture) && in_log_valid && !start_cmd;
        log_waddr = count_q[NB_ADDR-1:0];
    end

    // ---------------- log memory ----------------
    logic              rd_en;
    logic [NB_LOG-1:0] rd_data;

    assign rd_en = exec_q && (op_q == OP_LOG_READ);

    rf_log_ram #(
        .NB_LOG    (NB_LOG),
        .LOG_DEPTH (LOG_DEPTH),
        .NB_ADDR   (NB_ADDR)
    ) u_log_ram (
        .clk_i   (clock),
        .we_i    (log_we),
        .waddr_i (log_waddr),
        .wdata_i (in_log_data),
        .re_i    (rd_en),
        .raddr_i (payload_q[NB_ADDR-1:0]),
        .rdata_o (rd_data)
    );

    // ---------------- response path ----------------
    logic [NB_GPIOS-1:0] status_word;
    logic [NB_GPIOS-1:0] echo_word;
    logic [NB_GPIOS-1:0] read_word;

    always_comb begin
        status_word = '0;
        status_word[STATUS_CNT_LSB +: NB_CNT_FIELD] = count_q[NB_CNT_FIELD-1:0];
        status_word[1:0] = state_q;
        echo_word = '0;
        echo_word[PAYLOAD_MSB:0] = payload_q;
        read_word = '0;
        read_word[NB_LOG-1:0] = rd_data;
    end

    logic                resp_pend_q;
    logic                resp_is_read_q;
    logic [NB_GPIOS-1:0] resp_hold_q;
    logic [NB_GPIOS-1:0] resp_q;

    // Status/echo values are held one clock so every response lands at the same latency
    // as a RAM read.
    always_ff @(posedge clock or posedge in_reset) begin
        if (in_reset) begin
            resp_pend_q    <= 1'b0;
            resp_is_read_q <= 1'b0;
            resp_hold_q    <= '0;
            resp_q         <= '0;
        end else begin
            resp_pend_q <= 1'b0;
            if (exec_q) begin
                case (op_q)
                    OP_LOG_READ: begin
                        resp_pend_q    <= 1'b1;
                        resp_is_read_q <= 1'b1;
                    end
                    OP_LOG_STATUS: begin
                        resp_pend_q    <= 1'b1;
                        resp_is_read_q <= 1'b0;
                        resp_hold_q    <= status_word;
                    end
                    OP_ECHO: begin
                        resp_pend_q    <= 1'b1;
                        resp_is_read_q <= 1'b0;
                        resp_hold_q    <= echo_word;
                    end
                    default: ;
                endcase
            end
            if (resp_pend_q) begin
                resp_q <= resp_is_read_q ? read_word : resp_hold_q;
            end
        end
    end

    assign gpio.out_rf_to_micro_data = resp_q;

endmodule
